mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_access.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Brief    : Byte-serial load/store sequencer. Splits LB/LH/LW/SB/SH/SW
//            requests into single-byte memory cycles, assembles load bytes
//            little-endian and emits a one-cycle completion pulse.
// Revision : 1.0  initial release
// ============================================================================
module mem_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_order,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic              done_valid,
    output logic [31:0]       done_data,
    output logic [5:0]        done_order
);

    localparam logic [5:0] c_ORD_LB  = 6'd13;
    localparam logic [5:0] c_ORD_LH  = 6'd14;
    localparam logic [5:0] c_ORD_LW  = 6'd15;
    localparam logic [5:0] c_ORD_LBU = 6'd16;
    localparam logic [5:0] c_ORD_LHU = 6'd17;
    localparam logic [5:0] c_ORD_SB  = 6'd18;
    localparam logic [5:0] c_ORD_SH  = 6'd19;
    localparam logic [5:0] c_ORD_SW  = 6'd20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    // Byte count of an order; unknown orders report 0 so they finish
    // without touching memory.
    function automatic logic [2:0] f_count(input logic [5:0] ord);
        case (ord)
            c_ORD_LB, c_ORD_LBU, c_ORD_SB: f_count = 3'd1;
            c_ORD_LH, c_ORD_LHU, c_ORD_SH: f_count = 3'd2;
            c_ORD_LW, c_ORD_SW:            f_count = 3'd4;
            default:                       f_count = 3'd0;
        endcase
    endfunction

    function automatic logic f_is_store(input logic [5:0] ord);
        f_is_store = (ord == c_ORD_SB) || (ord == c_ORD_SH) || (ord == c_ORD_SW);
    endfunction

    state_t              r_state_q,      w_state_d;
    logic [2:0]          r_idx_q,        w_idx_d;
    logic [5:0]          r_order_q,      w_order_d;
    logic [ADDR_W-1:0]   r_addr_q,       w_addr_d;
    logic [31:0]         r_wdata_q,      w_wdata_d;
    logic [31:0]         r_buf_q,        w_buf_d;
    logic [ADDR_W-1:0]   r_mem_a_q,      w_mem_a_d;
    logic [7:0]          r_mem_dout_q,   w_mem_dout_d;
    logic                r_mem_wr_q,     w_mem_wr_d;
    logic                r_done_valid_q, w_done_valid_d;
    logic [31:0]         r_done_data_q,  w_done_data_d;
    logic [5:0]          r_done_order_q, w_done_order_d;

    logic                w_accept;
    logic [2:0]          w_n;
    logic [2:0]          w_idx_inc;
    logic [ADDR_W-1:0]   w_next_addr;
    logic [7:0]          w_store_byte;
    logic [31:0]         w_load_word;

    assign req_ready   = (r_state_q == ST_IDLE) && !rst_in;
    assign w_accept    = req_valid && req_ready && rdy_in && !flush;
    assign w_n         = f_count(r_order_q);
    assign w_idx_inc   = r_idx_q + 3'd1;
    // Natural ADDR_W-bit addition gives the required modulo wrap.
    assign w_next_addr = r_addr_q + ADDR_W'(w_idx_inc);

    assign mem_a      = r_mem_a_q;
    assign mem_dout   = r_mem_dout_q;
    // The memory stalls with us, so no write may be issued while stalled.
    assign mem_wr     = r_mem_wr_q && rdy_in;
    assign done_valid = r_done_valid_q;
    assign done_data  = r_done_data_q;
    assign done_order = r_done_order_q;

    // Select the store byte for the next write cycle.
    always_comb begin
        w_store_byte = r_wdata_q[7:0];
        case (w_idx_inc)
            3'd1:    w_store_byte = r_wdata_q[15:8];
            3'd2:    w_store_byte = r_wdata_q[23:16];
            3'd3:    w_store_byte = r_wdata_q[31:24];
            default: w_store_byte = r_wdata_q[7:0];
        endcase
    end

    // Merge the byte returned for address index idx-1 into the load buffer.
    always_comb begin
        w_load_word = r_buf_q;
        case (r_idx_q)
            3'd1:    w_load_word[7:0]   = mem_din;
            3'd2:    w_load_word[15:8]  = mem_din;
            3'd3:    w_load_word[23:16] = mem_din;
            3'd4:    w_load_word[31:24] = mem_din;
            default: w_load_word = r_buf_q;
        endcase
    end

    // Next-state and output-register logic; everything holds while stalled.
    always_comb begin
        w_state_d      = r_state_q;
        w_idx_d        = r_idx_q;
        w_order_d      = r_order_q;
        w_addr_d       = r_addr_q;
        w_wdata_d      = r_wdata_q;
        w_buf_d        = r_buf_q;
        w_mem_a_d      = r_mem_a_q;
        w_mem_dout_d   = r_mem_dout_q;
        w_mem_wr_d     = r_mem_wr_q;
        w_done_valid_d = 1'b0;
        w_done_data_d  = r_done_data_q;
        w_done_order_d = r_done_order_q;

        if (rdy_in) begin
            case (r_state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_order_d = req_order;
                        w_addr_d  = req_addr;
                        w_wdata_d = req_wdata;
                        w_idx_d   = 3'd0;
                        w_buf_d   = 32'd0;
                        if (f_is_store(req_order)) begin
                            w_state_d    = ST_STORE;
                            w_mem_a_d    = req_addr;
                            w_mem_dout_d = req_wdata[7:0];
                            w_mem_wr_d   = 1'b1;
                        end else begin
                            // Unknown orders run as zero-byte loads.
                            w_state_d = ST_LOAD;
                            if (f_count(req_order) != 3'd0) begin
                                w_mem_a_d = req_addr;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (flush) begin
                        w_state_d = ST_IDLE;
                        w_idx_d   = 3'd0;
                    end else if (r_idx_q == w_n) begin
                        w_state_d      = ST_IDLE;
                        w_idx_d        = 3'd0;
                        w_done_valid_d = 1'b1;
                        w_done_data_d  = (w_n == 3'd0) ? 32'd0 : w_load_word;
                        w_done_order_d = r_order_q;
                    end else begin
                        if (r_idx_q != 3'd0) begin
                            w_buf_d = w_load_word;
                        end
                        if (w_idx_inc < w_n) begin
                            w_mem_a_d = w_next_addr;
                        end
                        w_idx_d = w_idx_inc;
                    end
                end
                ST_STORE: begin
                    if (w_idx_inc < w_n) begin
                        w_mem_a_d    = w_next_addr;
                        w_mem_dout_d = w_store_byte;
                        w_idx_d      = w_idx_inc;
                    end else begin
                        w_state_d      = ST_IDLE;
                        w_idx_d        = 3'd0;
                        w_mem_wr_d     = 1'b0;
                        w_done_valid_d = 1'b1;
                        w_done_data_d  = 32'd0;
                        w_done_order_d = r_order_q;
                    end
                end
                default: begin
                    w_state_d  = ST_IDLE;
                    w_idx_d    = 3'd0;
                    w_mem_wr_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over stall/flush.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state_q      <= ST_IDLE;
            r_idx_q        <= 3'd0;
            r_order_q      <= 6'd0;
            r_addr_q       <= '0;
            r_wdata_q      <= 32'd0;
            r_buf_q        <= 32'd0;
            r_mem_a_q      <= '0;
            r_mem_dout_q   <= 8'd0;
            r_mem_wr_q     <= 1'b0;
            r_done_valid_q <= 1'b0;
            r_done_data_q  <= 32'd0;
            r_done_order_q <= 6'd0;
        end else begin
            r_state_q      <= w_state_d;
            r_idx_q        <= w_idx_d;
            r_order_q      <= w_order_d;
            r_addr_q       <= w_addr_d;
            r_wdata_q      <= w_wdata_d;
            r_buf_q        <= w_buf_d;
            r_mem_a_q      <= w_mem_a_d;
            r_mem_dout_q   <= w_mem_dout_d;
            r_mem_wr_q     <= w_mem_wr_d;
            r_done_valid_q <= w_done_valid_d;
            r_done_data_q  <= w_done_data_d;
            r_done_order_q <= w_done_order_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Brief    : Self-checking bench for mem_access with a byte memory model,
//            a write log and a completion scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access;

    logic        clk;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_order;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        done_valid;
    logic [31:0] done_data;
    logic [5:0]  done_order;

    mem_access #(.ADDR_W(32)) dut (
        .clk_in     (clk),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_order  (req_order),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_a      (mem_a),
        .mem_wr     (mem_wr),
        .done_valid (done_valid),
        .done_data  (done_data),
        .done_order (done_order)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  order;
        int          due;
    } exp_t;

    typedef struct {
        logic [5:0]  order;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_data;
        int          nwr;
    } vec_t;

    exp_t        sb[$];
    logic [39:0] wlog[$];
    logic [7:0]  mem [4096];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        prev_dv = 1'b0;

    // Cycle counter: constant between rising edges.
    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory, one-cycle read latency, stalls together with the DUT.
    always @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem[12'h100] <= 8'h11;
            mem[12'h101] <= 8'h22;
            mem[12'h102] <= 8'h33;
            mem[12'h103] <= 8'h44;
            mem[12'h007] <= 8'h80;
            mem[12'h002] <= 8'hCD;
            mem[12'h003] <= 8'hAB;
        end else if (mem_wr) begin
            mem[mem_a[11:0]] <= mem_dout;
            wlog.push_back({mem_a, mem_dout});
        end
        if (rdy_in) mem_din <= mem[mem_a[11:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bad(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event occurred that should not (cycle %0d)", nm, cyc);
    endtask

    // Completion monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (done_valid) begin
            chk("done_single", {31'd0, prev_dv}, 32'd0);
            if (sb.size() == 0) begin
                bad("done_unexpected");
            end else begin
                chk("done_data",  done_data, sb[0].data);
                chk("done_order", {26'd0, done_order}, {26'd0, sb[0].order});
                chk("done_cycle", 32'(cyc), 32'(sb[0].due));
                void'(sb.pop_front());
            end
        end
        prev_dv <= done_valid;
    end

    // Present one request and return just after its acceptance edge.
    task automatic issue(input logic [5:0] o, input logic [31:0] a,
                         input logic [31:0] wd, output int acc);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) bad("ready_timeout");
        req_valid = 1'b1;
        req_order = o;
        req_addr  = a;
        req_wdata = wd;
        acc       = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (sb.size() != 0) begin
            bad("done_timeout");
            sb.delete();
        end
    endtask

    task automatic check_writes(input logic [31:0] a, input logic [31:0] wd, input int n);
        logic [31:0] tmp;
        chk("wr_count", 32'(wlog.size()), 32'(n));
        for (int k = 0; k < n && k < wlog.size(); k++) begin
            tmp = wd >> (8 * k);
            chk("wr_addr", wlog[k][39:8], a + 32'(k));
            chk("wr_data", {24'd0, wlog[k][7:0]}, {24'd0, tmp[7:0]});
        end
        wlog.delete();
    endtask

    vec_t        vecs[13];
    int          acc;
    logic [31:0] pre_a;

    initial begin
        vecs[0]  = '{6'd15, 32'h100,      32'h0,        6, 32'h44332211, 0};
        vecs[1]  = '{6'd13, 32'h7,        32'h0,        3, 32'h00000080, 0};
        vecs[2]  = '{6'd14, 32'h2,        32'h0,        4, 32'h0000ABCD, 0};
        vecs[3]  = '{6'd16, 32'h7,        32'h0,        3, 32'h00000080, 0};
        vecs[4]  = '{6'd17, 32'h101,      32'h0,        4, 32'h00003322, 0};
        vecs[5]  = '{6'd19, 32'h200,      32'hDEADBEEF, 3, 32'h0,        2};
        vecs[6]  = '{6'd20, 32'h300,      32'h01020304, 5, 32'h0,        4};
        vecs[7]  = '{6'd15, 32'h300,      32'h0,        6, 32'h01020304, 0};
        vecs[8]  = '{6'd18, 32'h7,        32'h000000C3, 2, 32'h0,        1};
        vecs[9]  = '{6'd13, 32'h7,        32'h0,        3, 32'h000000C3, 0};
        vecs[10] = '{6'd0,  32'h55,       32'h0,        2, 32'h0,        0};
        vecs[11] = '{6'd21, 32'h66,       32'hFFFFFFFF, 2, 32'h0,        0};
        vecs[12] = '{6'd15, 32'h301,      32'h0,        6, 32'h5E010203, 0};

        clk = 1'b0; rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
        req_valid = 1'b0; req_order = 6'd0; req_addr = 32'd0; req_wdata = 32'd0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",      {31'd0, req_ready}, 32'd0);
        chk("rst_mem_a",      mem_a, 32'd0);
        chk("rst_mem_dout",   {24'd0, mem_dout}, 32'd0);
        chk("rst_mem_wr",     {31'd0, mem_wr}, 32'd0);
        chk("rst_done_valid", {31'd0, done_valid}, 32'd0);
        chk("rst_done_data",  done_data, 32'd0);
        chk("rst_done_order", {26'd0, done_order}, 32'd0);
        rst_in = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Table-driven requests
        for (int i = 0; i < 13; i++) begin
            pre_a = mem_a;
            issue(vecs[i].order, vecs[i].addr, vecs[i].wdata, acc);
            sb.push_back('{data: vecs[i].exp_data, order: vecs[i].order, due: acc + vecs[i].lat});
            drain();
            check_writes(vecs[i].addr, vecs[i].wdata, vecs[i].nwr);
            if (vecs[i].order < 6'd13 || vecs[i].order > 6'd20)
                chk("bad_order_mem_a", mem_a, pre_a);
            chk("mem_wr_idle", {31'd0, mem_wr}, 32'd0);
        end

        // Stall in the middle of LW: three frozen edges
        issue(6'd15, 32'h100, 32'h0, acc);
        sb.push_back('{data: 32'h44332211, order: 6'd15, due: acc + 9});
        @(negedge clk);
        @(negedge clk);
        rdy_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_ld_mem_wr", {31'd0, mem_wr}, 32'd0);
            chk("stall_ld_mem_a",  mem_a, 32'h101);
        end
        rdy_in = 1'b1;
        drain();
        check_writes(32'h0, 32'h0, 0);

        // Stall in the middle of SW: strobe must drop while stalled
        issue(6'd20, 32'h500, 32'h55667788, acc);
        sb.push_back('{data: 32'h0, order: 6'd20, due: acc + 7});
        @(negedge clk);
        @(negedge clk);
        rdy_in = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stall_st_mem_wr", {31'd0, mem_wr}, 32'd0);
            chk("stall_st_mem_a",  mem_a, 32'h501);
        end
        rdy_in = 1'b1;
        drain();
        check_writes(32'h500, 32'h55667788, 4);

        // Requests while busy are ignored
        issue(6'd15, 32'h100, 32'h0, acc);
        sb.push_back('{data: 32'h44332211, order: 6'd15, due: acc + 6});
        @(negedge clk);
        req_valid = 1'b1; req_order = 6'd20; req_addr = 32'h600; req_wdata = 32'h99999999;
        chk("busy_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        drain();
        check_writes(32'h0, 32'h0, 0);

        // Flush aborts LW
        issue(6'd15, 32'h100, 32'h0, acc);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", {31'd0, req_ready}, 32'd1);
        repeat (6) begin
            @(negedge clk);
            chk("flush_no_done", {31'd0, done_valid}, 32'd0);
        end

        // Flush has no effect on SW, and blocks acceptance in IDLE
        issue(6'd20, 32'h400, 32'hA1B2C3D4, acc);
        flush = 1'b1;
        sb.push_back('{data: 32'h0, order: 6'd20, due: acc + 5});
        drain();
        check_writes(32'h400, 32'hA1B2C3D4, 4);
        req_valid = 1'b1; req_order = 6'd13; req_addr = 32'h7;
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
        repeat (5) @(negedge clk);
        chk("flush_idle_mem_a", mem_a, 32'h403);

        // Address wrap
        issue(6'd18, 32'hFFFFFFFF, 32'h00000077, acc);
        sb.push_back('{data: 32'h0, order: 6'd18, due: acc + 2});
        drain();
        check_writes(32'hFFFFFFFF, 32'h00000077, 1);
        issue(6'd14, 32'hFFFFFFFF, 32'h0, acc);
        sb.push_back('{data: 32'h00005A77, order: 6'd14, due: acc + 4});
        @(negedge clk);
        chk("wrap_mem_a0", mem_a, 32'hFFFFFFFF);
        @(negedge clk);
        chk("wrap_mem_a1", mem_a, 32'h0);
        drain();

        // Reset in the middle of LW
        issue(6'd15, 32'h100, 32'h0, acc);
        @(negedge clk);
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        chk("midrst_ready",      {31'd0, req_ready}, 32'd0);
        chk("midrst_mem_a",      mem_a, 32'd0);
        chk("midrst_mem_wr",     {31'd0, mem_wr}, 32'd0);
        chk("midrst_done_valid", {31'd0, done_valid}, 32'd0);
        chk("midrst_done_data",  done_data, 32'd0);
        chk("midrst_done_order", {26'd0, done_order}, 32'd0);
        rst_in = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("midrst_no_done", {31'd0, done_valid}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
